// File: rtl/imem_fetch_responder_if.sv
// Fetch-path handshake bundle between the F-stage (master) and the
// instruction-memory responder (slave): request address channel and
// response instruction channel, each with valid/ready.
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: one outstanding fetch at a time, a fixed
// number of wait states before the response, and a boot-time load port
// that fills the word array. Byte address BASE_ADDR maps to word 0.
module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          AW          = 12,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    imem_fetch_responder_if.slave  fetch,
    input  logic                   ld_we,
    input  logic [AW-1:0]          ld_addr,
    input  logic [31:0]            ld_data,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte span of the array; 33 bits so DEPTH_WORDS*4 cannot overflow.
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [31:0]     addr_reg;
    logic            err_reg;
    logic [31:0]     rsp_addr_reg;
    logic            rsp_err_reg;
    logic [31:0]     rd_word_reg;
    logic            accept;
    logic            load_rsp;
    logic [31:0]     off_req;
    logic            req_err;
    logic [AW-1:0]   rd_idx;

    logic [31:0] mem [DEPTH_WORDS];

    // Request decode: misaligned, below base, or beyond the array (no wrap).
    assign off_req = fetch.req_addr - BASE_ADDR;
    assign req_err = (fetch.req_addr[1:0] != 2'b00)
                  || (fetch.req_addr < BASE_ADDR)
                  || ({1'b0, off_req} >= SPAN);
    assign accept  = fetch.req_valid && (state_reg == ST_IDLE);
    assign rd_idx  = AW'((addr_reg - BASE_ADDR) >> 2);

    // Word array: load-port writes in any state; the response read is taken
    // on the RESP-entry edge, so a same-edge write returns the old word.
    // Contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
        if (load_rsp && !err_reg) begin
            rd_word_reg <= mem[rd_idx];
        end
    end

    // State, wait counter, latched request and held response fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= 32'd0;
            err_reg      <= 1'b0;
            rsp_addr_reg <= 32'd0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= fetch.req_addr;
                err_reg  <= req_err;
            end
            if (load_rsp) begin
                rsp_addr_reg <= addr_reg;
                rsp_err_reg  <= err_reg;
            end
        end
    end

    // Next-state logic. The accept edge always lands in WAIT for one decode
    // cycle; errors and zero wait states leave on the following edge, which
    // places the response WAIT_CYCLES+1 edges after the accept.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_rsp   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_WAIT;
                    cnt_next   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (err_reg || (cnt_reg == 4'd0)) begin
                    state_next = ST_RESP;
                    load_rsp   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (fetch.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign fetch.req_ready = (state_reg == ST_IDLE);
    assign fetch.rsp_valid = (state_reg == ST_RESP);
    assign fetch.rsp_addr  = rsp_addr_reg;
    assign fetch.rsp_err   = rsp_err_reg;
    // Instruction is forced to zero outside a good response, so reset and
    // error responses present 0 without clearing the array read register.
    assign fetch.rsp_instr = ((state_reg == ST_RESP) && !rsp_err_reg) ? rd_word_reg : 32'd0;
    assign busy            = (state_reg != ST_IDLE);

endmodule
